// File: rtl/op_sched_ctrl_if.sv
// ============================================================================
// op_sched_ctrl_if : request/grant and accumulator bus of op_sched_ctrl
// Revision 1.0
// ============================================================================
`default_nettype none

interface op_sched_ctrl_if #(
   parameter int ACC_W = 14
) ();
   logic             clear;
   logic [3:0]       req;
   logic [7:0]       op;
   logic [3:0]       ack;
   logic             busy;
   logic [ACC_W-1:0] acc;
   logic             overflow;

   modport master (
      output clear, req, op,
      input  ack, busy, acc, overflow
   );

   modport slave (
      input  clear, req, op,
      output ack, busy, acc, overflow
   );
endinterface

`default_nettype wire

// File: rtl/op_sched_ctrl.sv
// ============================================================================
// op_sched_ctrl : round-robin scheduler of four requesters onto one accumulator
// Revision 1.0
// ============================================================================
`default_nettype none

module op_sched_ctrl #(
   parameter int COOLDOWN = 1024,
   parameter int ACC_W    = 14,
   parameter int MAX_VAL  = 9999
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   op_sched_ctrl_if.slave  bus
);

   localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
   localparam int RES_W = ACC_W + 2;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(COOLDOWN - 1);
   localparam logic [RES_W-1:0] C_MAX      = RES_W'(MAX_VAL);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_EXEC2 = 2'd2,
      S_COOL  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_ptr;
   logic [1:0]       r_win;
   logic [1:0]       r_op;
   logic [RES_W-1:0] r_tmp;
   logic [CNT_W-1:0] r_cnt;
   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;

   logic             w_found;
   logic [1:0]       w_pick;
   logic [1:0]       w_idx;
   logic [1:0]       w_pick_op;
   logic [RES_W-1:0] w_acc_ext;
   logic [RES_W-1:0] w_res;
   logic             w_commit;

   // Round-robin search starting at the pointer, wrapping mod 4
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_ptr;
      w_idx   = r_ptr;
      for (int i = 0; i < 4; i++) begin
         w_idx = r_ptr + 2'(i);
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   assign w_pick_op = bus.op[{w_pick, 1'b0} +: 2];
   assign w_acc_ext = {2'b00, r_acc};

   always_comb begin
      w_res = w_acc_ext;
      case (r_op)
         2'b00:   w_res = w_acc_ext + RES_W'(1);
         2'b01:   w_res = w_acc_ext + RES_W'(3);
         2'b10:   w_res = w_acc_ext << 1;
         default: w_res = r_tmp + w_acc_ext;
      endcase
   end

   assign w_commit = ((r_state == S_EXEC) && (r_op != 2'b11)) || (r_state == S_EXEC2);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_found) w_state_nxt = S_EXEC;
         S_EXEC:  w_state_nxt = (r_op == 2'b11) ? S_EXEC2 : S_COOL;
         S_EXEC2: w_state_nxt = S_COOL;
         S_COOL:  if (r_cnt == C_CNT_LAST) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else if (bus.clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Clear drops any in-flight result but keeps the fairness pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= 2'd0;
         r_win <= 2'd0;
         r_op  <= 2'd0;
         r_tmp <= '0;
         r_cnt <= '0;
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (bus.clear) begin
         r_cnt <= '0;
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else begin
         if ((r_state == S_IDLE) && w_found) begin
            r_win <= w_pick;
            r_op  <= w_pick_op;
            r_ptr <= w_pick + 2'd1;
         end
         if (r_state == S_EXEC) begin
            r_tmp <= w_acc_ext << 1;
         end
         if (w_commit) begin
            if (w_res > C_MAX) begin
               r_ovf <= 1'b1;
            end else if (!r_ovf) begin
               r_acc <= w_res[ACC_W-1:0];
            end
         end
         if (r_state == S_COOL) begin
            r_cnt <= (r_cnt == C_CNT_LAST) ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.ack      = (r_state == S_EXEC) ? (4'b0001 << r_win) : 4'b0000;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.acc      = r_acc;
   assign bus.overflow = r_ovf;

endmodule

`default_nettype wire
